// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, arbiter state encoding and the
// default launch-watchdog limit.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search over NUM_REQ requesters. The pointer holds the
// index where the next search starts and advances past the winner on update.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [2:0]         winner,
  output logic               valid
);

  logic [2:0] ptr;
  logic [7:0] req_pad;
  logic [3:0] idx;

  assign req_pad = 8'(req);

  // Walk from the farthest offset down so the closest hit to ptr wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (req_pad[idx[2:0]]) begin
        winner = idx[2:0];
        valid  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters, round-robin.
// Define UART_ARB_TIMEOUT_EN to compile in the launch watchdog (err pulses).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             err,
  output logic                           tx_wr_en,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [2:0]                     active_id,
  output logic                           arb_busy,
  output arb_state_t                     state_dbg
);

  // Handshake with the transmitter: tx_wr_en is held high through LAUNCH
  // until tx_busy is sampled high, which is taken as acceptance of the byte;
  // the byte is complete when tx_busy is next sampled low.

  arb_state_t                 state, state_nxt;
  logic [2:0]                 winner, active_q;
  logic                       win_valid, grant, timeout;
  logic [UART_DATA_W-1:0]     sel_byte;
  logic [NUM_REQ-1:0]         id_onehot;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (grant),
    .winner (winner),
    .valid  (win_valid)
  );

  assign grant     = (state == IDLE) && win_valid && !tx_busy;
  assign id_onehot = NUM_REQ'(1) << active_q;

  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == 3'(k)) sel_byte = req_data[k*UART_DATA_W +: UART_DATA_W];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   wd_cnt;
  logic [NUM_REQ-1:0] err_q;

  // LAUNCH lasts exactly TIMEOUT_CYCLES cycles before giving up.
  assign timeout = (state == LAUNCH) && !tx_busy &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= '0;
    end else begin
      err_q <= timeout ? id_onehot : '0;
      if (grant)                wd_cnt <= '0;
      else if (state == LAUNCH) wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = LAUNCH;
      LAUNCH:  if (tx_busy) state_nxt = BUSY;
               else if (timeout) state_nxt = IDLE;
      BUSY:    if (!tx_busy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      active_q <= '0;
      tx_data  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        active_q <= winner;
        tx_data  <= sel_byte;
      end
    end
  end

  assign tx_wr_en  = (state == LAUNCH);
  assign ack       = (state == DONE) ? id_onehot : '0;
  assign active_id = (state == IDLE) ? 3'd0 : active_q;
  assign arb_busy  = (state != IDLE);
  assign state_dbg = state;

endmodule
